mano_seq_ctrl: RTL and testbench
================================

MANO_SEQ_CTRL -- requirements
Module: mano_seq_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 16: data/instruction width; legal range DW = AW+4.
REQ-002 SHALL provide parameter AW, default 12: address width; legal AW >= 12.
REQ-003 SHALL provide port CLK  in  1  sole clock, all state on rising edge.
REQ-004 SHALL provide port RST_N  in  1  asynchronous active-low reset.
REQ-005 SHALL provide port START  in  1  single-cycle pulse; leaves halt and resumes fetch.
REQ-006 SHALL provide port IR  in  DW  instruction register contents from datapath.
REQ-007 SHALL provide port FLAGS  in  5  {E, AC_MSB, AC_ZERO, DR_ZERO, AC_LSB} status from datapath.
REQ-008 SHALL provide port FGI_FGO  in  2  {FGI, FGO} I/O flags.
REQ-009 SHALL provide port LD  out  7  load strobes; bit 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 OUTR.
REQ-010 SHALL provide port INC  out  4  increment strobes; bit 0 AR, 1 PC, 2 DR, 3 AC.
REQ-011 SHALL provide port CLR  out  3  clear strobes; bit 0 AR, 1 PC, 2 AC.
REQ-012 SHALL provide port BUS_SEL  out  3  bus source; 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
REQ-013 SHALL provide port ALU_OP  out  4  0 none, 1 AND, 2 ADD, 3 LOAD DR, 4 INPR, 5 CMA, 6 CIR, 7 CIL, 8 CLE, 9 CME.
REQ-014 SHALL provide port READ / WRITE  out  1 each  memory strobes, mutually exclusive.
REQ-015 SHALL provide port HALT  out  1  high while run flip-flop S is 0.
REQ-016 SHALL provide port SC  out  4  current timing count; Tn = (SC==n).

Function
REQ-017 SHALL decode D = IR[DW-2:DW-4], I = IR[DW-1], latched into internal I flop at T2.
REQ-018 Fetch SHALL be: T0 BUS_SEL=2, LD[0]; T1 READ, BUS_SEL=7, LD[4], INC[1]; T2 BUS_SEL=5, LD[0].
REQ-019 At T3 with D!=7 and I=1, SHALL assert READ, BUS_SEL=7, LD[0] (indirect); with I=0 no strobes.
REQ-020 Memory-reference execution SHALL start at T4: AND/ADD/LDA T4 READ+LD[2], T5 ALU_OP 1/2/3 + LD[3]; STA T4 BUS_SEL=4+WRITE; BUN T4 BUS_SEL=1+LD[1]; BSA T4 BUS_SEL=2+WRITE+INC[0], T5 BUS_SEL=1+LD[1]; ISZ T4 READ+LD[2], T5 INC[2], T6 BUS_SEL=3+WRITE, INC[1] iff DR_ZERO.
REQ-021 Each instruction's last step SHALL clear SC to 0 at the next edge; otherwise SC increments, wrapping 15->0 only by explicit clear.
REQ-022 Register-reference (D=7, I=0) and I/O (D=7, I=1) SHALL execute entirely in T3 by IR[11:0] one-hot bit, then clear SC.
REQ-023 Skip instructions (SPA, SNA, SZA, SZE, SKI, SKO) SHALL assert INC[1] in T3 when FLAGS/FGI_FGO condition true.
REQ-024 HLT SHALL clear S; while S=0 SC holds 0 and all strobes SHALL be 0; START sets S; START while S=1 ignored.
REQ-025 More than one IR[11:0] bit set in T3 SHALL assert the union of their strobes; HLT among them still clears S.

Reset
REQ-026 RST_N low SHALL immediately force SC=0, S=0, I=0, R=0, IEN=0; all strobes 0, HALT=1.
REQ-027 Reset mid-instruction SHALL abandon it; after release no strobe until START.

Configuration
REQ-028 Macro MANO_INTERRUPT_EN compiled in SHALL add the interrupt flop R, IEN, ION/IOF, SKI/SKO and interrupt cycle.
REQ-029 With it, R SHALL set at any edge where SC in {0,1,2}, R=0, IEN=1, FGI|FGO; with R=1, T0 SHALL CLR[0]+BUS_SEL=2+LD[5]; T1 BUS_SEL=6+WRITE+CLR[1]; T2 INC[1], clear IEN, R, SC.
REQ-030 Without it, R and IEN SHALL be constant 0, FGI_FGO ignored, ION/IOF/SKI/SKO SHALL execute as no-ops that still clear SC at T3.

Verification
REQ-031 Reset then START; IR=0x2123 (LDA direct) -> LD[2]+READ at SC=4, ALU_OP=3+LD[3] at SC=5, SC=0 at next edge.
REQ-032 IR=0xC050 (BUN indirect) -> READ+LD[0] at SC=3, BUS_SEL=1+LD[1] at SC=4.
REQ-033 IR=0x6040 (ISZ) with DR_ZERO=1 at SC=6 -> WRITE+INC[1] at SC=6; with DR_ZERO=0 -> no INC[1].
REQ-034 IR=0x7001 (HLT) -> HALT=1 after T3, strobes 0 for 20 cycles; START pulse -> T0 fetch resumes.
REQ-035 MANO_INTERRUPT_EN on, ION executed, FGI=1 at SC=1 -> R=1, next T0..T2 interrupt cycle, IEN=0 after.
REQ-036 RST_N low at SC=5 of ADD -> SC=0, HALT=1 immediately, no LD[3] pulse.

Source files
------------

// File: rtl/mano_seq_ctrl.sv
// Timing sequencer and control-strobe decoder for the Mano basic computer.
// Define MANO_INTERRUPT_EN to build in R/IEN, ION/IOF, SKI/SKO and the interrupt cycle.
module mano_seq_ctrl #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [DW-1:0] IR,
    input  logic [4:0]    FLAGS,
    input  logic [1:0]    FGI_FGO,
    output logic [6:0]    LD,
    output logic [3:0]    INC,
    output logic [2:0]    CLR,
    output logic [2:0]    BUS_SEL,
    output logic [3:0]    ALU_OP,
    output logic          READ,
    output logic          WRITE,
    output logic          HALT,
    output logic [3:0]    SC
);

`ifdef MANO_INTERRUPT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
        OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7
    } op_e;

    logic [3:0]    sc_q, sc_d;
    logic          s_q, s_d;
    logic          i_q, i_d;
    logic          r_q, r_d;
    logic          ien_q, ien_d;
    logic          irq_q, irq_d;
    logic          last;
    op_e           op;
    logic [AW-1:0] adr;
    logic          unused_ok;

    assign op        = op_e'(IR[DW-2:DW-4]);
    assign adr       = IR[AW-1:0];
    assign unused_ok = ^{FLAGS[0], adr};
    assign HALT      = ~s_q;
    assign SC        = sc_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sc_q  <= 4'd0;
            s_q   <= 1'b0;
            i_q   <= 1'b0;
            r_q   <= 1'b0;
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            s_q   <= s_d;
            i_q   <= i_d;
            r_q   <= r_d;
            ien_q <= ien_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        LD      = '0;
        INC     = '0;
        CLR     = '0;
        BUS_SEL = '0;
        ALU_OP  = '0;
        READ    = 1'b0;
        WRITE   = 1'b0;
        s_d     = s_q;
        i_d     = i_q;
        r_d     = r_q;
        ien_d   = ien_q;
        irq_d   = irq_q;
        last    = 1'b0;
        if (!s_q) begin
            s_d = START;
        end else if (irq_q || (r_q && sc_q == 4'd0)) begin
            // irq_q keeps T1/T2 in the interrupt cycle once R is seen at T0
            case (sc_q)
                4'd0: begin
                    CLR[0] = 1'b1; BUS_SEL = 3'd2; LD[5] = 1'b1; irq_d = 1'b1;
                end
                4'd1: begin
                    BUS_SEL = 3'd6; WRITE = 1'b1; CLR[1] = 1'b1;
                end
                default: begin
                    INC[1] = 1'b1; ien_d = 1'b0; r_d = 1'b0;
                    irq_d = 1'b0; last = 1'b1;
                end
            endcase
        end else begin
            case (sc_q)
                4'd0: begin
                    BUS_SEL = 3'd2; LD[0] = 1'b1;
                end
                4'd1: begin
                    READ = 1'b1; BUS_SEL = 3'd7; LD[4] = 1'b1; INC[1] = 1'b1;
                end
                4'd2: begin
                    BUS_SEL = 3'd5; LD[0] = 1'b1; i_d = IR[DW-1];
                end
                4'd3: begin
                    if (op != OP_REG) begin
                        if (i_q) begin
                            READ = 1'b1; BUS_SEL = 3'd7; LD[0] = 1'b1;
                        end
                    end else if (!i_q) begin
                        last = 1'b1;
                        if (adr[11]) CLR[2] = 1'b1;
                        if (adr[10]) ALU_OP = 4'd8;
                        if (adr[9]) begin ALU_OP = 4'd5; LD[3] = 1'b1; end
                        if (adr[8]) ALU_OP = 4'd9;
                        if (adr[7]) begin ALU_OP = 4'd6; LD[3] = 1'b1; end
                        if (adr[6]) begin ALU_OP = 4'd7; LD[3] = 1'b1; end
                        if (adr[5]) INC[3] = 1'b1;
                        if (adr[4] && !FLAGS[3]) INC[1] = 1'b1;
                        if (adr[3] && FLAGS[3]) INC[1] = 1'b1;
                        if (adr[2] && FLAGS[2]) INC[1] = 1'b1;
                        if (adr[1] && !FLAGS[4]) INC[1] = 1'b1;
                        if (adr[0]) s_d = 1'b0;
                    end else begin
                        last = 1'b1;
                        if (adr[11]) begin ALU_OP = 4'd4; LD[3] = 1'b1; end
                        if (adr[10]) begin BUS_SEL = 3'd4; LD[6] = 1'b1; end
                        if (INT_EN && adr[9] && FGI_FGO[1]) INC[1] = 1'b1;
                        if (INT_EN && adr[8] && FGI_FGO[0]) INC[1] = 1'b1;
                        if (INT_EN && adr[7]) ien_d = 1'b1;
                        if (INT_EN && adr[6]) ien_d = 1'b0;
                    end
                end
                4'd4: begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            READ = 1'b1; BUS_SEL = 3'd7; LD[2] = 1'b1;
                        end
                        OP_STA: begin
                            BUS_SEL = 3'd4; WRITE = 1'b1; last = 1'b1;
                        end
                        OP_BUN: begin
                            BUS_SEL = 3'd1; LD[1] = 1'b1; last = 1'b1;
                        end
                        OP_BSA: begin
                            BUS_SEL = 3'd2; WRITE = 1'b1; INC[0] = 1'b1;
                        end
                        default: last = 1'b1;
                    endcase
                end
                4'd5: begin
                    case (op)
                        OP_AND: begin ALU_OP = 4'd1; LD[3] = 1'b1; last = 1'b1; end
                        OP_ADD: begin ALU_OP = 4'd2; LD[3] = 1'b1; last = 1'b1; end
                        OP_LDA: begin ALU_OP = 4'd3; LD[3] = 1'b1; last = 1'b1; end
                        OP_BSA: begin BUS_SEL = 3'd1; LD[1] = 1'b1; last = 1'b1; end
                        OP_ISZ: INC[2] = 1'b1;
                        default: last = 1'b1;
                    endcase
                end
                4'd6: begin
                    last = 1'b1;
                    if (op == OP_ISZ) begin
                        BUS_SEL = 3'd3; WRITE = 1'b1; INC[1] = FLAGS[1];
                    end
                end
                default: last = 1'b1;
            endcase
        end
        // interrupt request only sampled during fetch of a running machine
        if (INT_EN && s_q && !r_q && ien_q && (|FGI_FGO) && sc_q <= 4'd2)
            r_d = 1'b1;
        if (!s_q || last)
            sc_d = 4'd0;
        else if (sc_q != 4'd15)
            sc_d = sc_q + 4'd1;
        else
            sc_d = sc_q;
    end

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Table-driven scoreboard bench for mano_seq_ctrl.
module tb_mano_seq_ctrl;

    logic        CLK, RST_N, START;
    logic [15:0] IR;
    logic [4:0]  FLAGS;
    logic [1:0]  FGI_FGO;
    logic [6:0]  LD;
    logic [3:0]  INC;
    logic [2:0]  CLR, BUS_SEL;
    logic [3:0]  ALU_OP, SC;
    logic        READ, WRITE, HALT;
    logic [27:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    logic [27:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        logic [15:0] ir;
        logic [4:0]  flags;
        int          n;
        logic [27:0] e3, e4, e5, e6;
    } vec_t;

    vec_t tbl[$];

    mano_seq_ctrl #(.DW(16), .AW(12)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .IR(IR),
        .FLAGS(FLAGS), .FGI_FGO(FGI_FGO), .LD(LD), .INC(INC),
        .CLR(CLR), .BUS_SEL(BUS_SEL), .ALU_OP(ALU_OP), .READ(READ),
        .WRITE(WRITE), .HALT(HALT), .SC(SC)
    );

    assign obs = {LD, INC, CLR, BUS_SEL, ALU_OP, READ, WRITE, HALT, SC};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [27:0] mk(logic [6:0] ld, logic [3:0] inc,
                                       logic [2:0] clr, logic [2:0] bus,
                                       logic [3:0] alu, logic rd, logic wr,
                                       logic [3:0] sc);
        return {ld, inc, clr, bus, alu, rd, wr, 1'b0, sc};
    endfunction

    function automatic logic [27:0] none(logic [3:0] sc);
        return mk(7'd0, 4'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, sc);
    endfunction

    function automatic logic [27:0] halted();
        return {7'd0, 4'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0};
    endfunction

    task automatic check_pop();
        logic [27:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", t, obs, e);
        end
    endtask

    task automatic check_now(input logic [27:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_pop();
    endtask

    task automatic step(input logic [27:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge CLK);
        check_pop();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic add(input logic [15:0] ir, input logic [4:0] fl, input int n,
                       input logic [27:0] e3, input logic [27:0] e4,
                       input logic [27:0] e5, input logic [27:0] e6);
        vec_t v;
        v.ir = ir; v.flags = fl; v.n = n;
        v.e3 = e3; v.e4 = e4; v.e5 = e5; v.e6 = e6;
        tbl.push_back(v);
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [4:0] fl,
                             input int n, input logic [27:0] e3,
                             input logic [27:0] e4, input logic [27:0] e5,
                             input logic [27:0] e6, input logic [1:0] fgi1,
                             input string nm);
        logic [27:0] ex[4];
        ex = '{e3, e4, e5, e6};
        IR = ir;
        FLAGS = fl;
        step(mk(7'b0000001, 4'd0, 3'd0, 3'd2, 4'd0, 1'b0, 1'b0, 4'd0),
             {nm, " T0"});
        FGI_FGO = fgi1;
        step(mk(7'b0010000, 4'b0010, 3'd0, 3'd7, 4'd0, 1'b1, 1'b0, 4'd1),
             {nm, " T1"});
        step(mk(7'b0000001, 4'd0, 3'd0, 3'd5, 4'd0, 1'b0, 1'b0, 4'd2),
             {nm, " T2"});
        for (int k = 0; k < n; k++)
            step(ex[k], $sformatf("%s T%0d", nm, k + 3));
    endtask

    initial begin
        logic [27:0] z;
        z = none(4'd0);
        // {ir, flags, exec steps, T3..T6 expectations}
        add(16'h2123, 5'b00000, 3, none(3),
            mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
            mk(7'b0001000, 0, 0, 0, 3, 0, 0, 5), z);
        add(16'hC050, 5'b00000, 2,
            mk(7'b0000001, 0, 0, 7, 0, 1, 0, 3),
            mk(7'b0000010, 0, 0, 1, 0, 0, 0, 4), z, z);
        add(16'h4050, 5'b00000, 2, none(3),
            mk(7'b0000010, 0, 0, 1, 0, 0, 0, 4), z, z);
        add(16'h6040, 5'b00010, 4, none(3),
            mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
            mk(7'd0, 4'b0100, 0, 0, 0, 0, 0, 5),
            mk(7'd0, 4'b0010, 0, 3, 0, 0, 1, 6));
        add(16'h6040, 5'b00000, 4, none(3),
            mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
            mk(7'd0, 4'b0100, 0, 0, 0, 0, 0, 5),
            mk(7'd0, 4'b0000, 0, 3, 0, 0, 1, 6));
        add(16'h0123, 5'b00000, 3, none(3),
            mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
            mk(7'b0001000, 0, 0, 0, 1, 0, 0, 5), z);
        add(16'h1123, 5'b00000, 3, none(3),
            mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
            mk(7'b0001000, 0, 0, 0, 2, 0, 0, 5), z);
        add(16'h3123, 5'b00000, 2, none(3),
            mk(7'd0, 0, 0, 4, 0, 0, 1, 4), z, z);
        add(16'h5123, 5'b00000, 3, none(3),
            mk(7'd0, 4'b0001, 0, 2, 0, 0, 1, 4),
            mk(7'b0000010, 0, 0, 1, 0, 0, 0, 5), z);
        add(16'h7800, 5'b00000, 1, mk(7'd0, 0, 3'b100, 0, 0, 0, 0, 3), z, z, z);
        add(16'h7200, 5'b00000, 1, mk(7'b0001000, 0, 0, 0, 5, 0, 0, 3), z, z, z);
        add(16'h7040, 5'b00000, 1, mk(7'b0001000, 0, 0, 0, 7, 0, 0, 3), z, z, z);
        add(16'h7020, 5'b00000, 1, mk(7'd0, 4'b1000, 0, 0, 0, 0, 0, 3), z, z, z);
        add(16'h7010, 5'b00000, 1, mk(7'd0, 4'b0010, 0, 0, 0, 0, 0, 3), z, z, z);
        add(16'h7010, 5'b01000, 1, none(3), z, z, z);
        add(16'h7008, 5'b01000, 1, mk(7'd0, 4'b0010, 0, 0, 0, 0, 0, 3), z, z, z);
        add(16'h7004, 5'b00100, 1, mk(7'd0, 4'b0010, 0, 0, 0, 0, 0, 3), z, z, z);
        add(16'h7002, 5'b10000, 1, none(3), z, z, z);
        add(16'hF400, 5'b00000, 1, mk(7'b1000000, 0, 0, 4, 0, 0, 0, 3), z, z, z);
        add(16'hF800, 5'b00000, 1, mk(7'b0001000, 0, 0, 0, 4, 0, 0, 3), z, z, z);
        add(16'hF200, 5'b00000, 1, none(3), z, z, z);
        add(16'h7820, 5'b00000, 1, mk(7'd0, 4'b1000, 3'b100, 0, 0, 0, 0, 3), z, z, z);

        RST_N = 1'b1; START = 1'b0; IR = '0; FLAGS = '0; FGI_FGO = '0;
        #2 RST_N = 1'b0;
        @(negedge CLK);
        check_now(halted(), "reset state");
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int k = 0; k < 3; k++)
            step(halted(), "idle before start");
        start_pulse();

        for (int i = 0; i < tbl.size(); i++)
            run_instr(tbl[i].ir, tbl[i].flags, tbl[i].n, tbl[i].e3,
                      tbl[i].e4, tbl[i].e5, tbl[i].e6, 2'b00,
                      $sformatf("vec%0d", i));

        START = 1'b1;
        run_instr(16'h4050, 5'b00000, 2, none(3),
                  mk(7'b0000010, 0, 0, 1, 0, 0, 0, 4), z, z, 2'b00,
                  "start while running");
        START = 1'b0;

        run_instr(16'h7001, 5'b00000, 1, none(3), z, z, z, 2'b00, "HLT");
        for (int k = 0; k < 20; k++)
            step(halted(), $sformatf("halted %0d", k));
        start_pulse();
        run_instr(16'h2123, 5'b00000, 3, none(3),
                  mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
                  mk(7'b0001000, 0, 0, 0, 3, 0, 0, 5), z, 2'b00,
                  "resume LDA");

        run_instr(16'h7801, 5'b00000, 1, mk(7'd0, 0, 3'b100, 0, 0, 0, 0, 3),
                  z, z, z, 2'b00, "CLA+HLT");
        step(halted(), "CLA+HLT halted");
        start_pulse();

        IR = 16'h1123;
        FLAGS = '0;
        step(mk(7'b0000001, 0, 0, 2, 0, 0, 0, 0), "ADD T0");
        step(mk(7'b0010000, 4'b0010, 0, 7, 0, 1, 0, 1), "ADD T1");
        step(mk(7'b0000001, 0, 0, 5, 0, 0, 0, 2), "ADD T2");
        step(none(3), "ADD T3");
        step(mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4), "ADD T4");
        RST_N = 1'b0;
        #1;
        check_now(halted(), "reset at T5");
        @(negedge CLK);
        check_now(halted(), "reset held");
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int k = 0; k < 3; k++)
            step(halted(), "idle after reset");
        start_pulse();
        run_instr(16'h1123, 5'b00000, 3, none(3),
                  mk(7'b0000100, 0, 0, 7, 0, 1, 0, 4),
                  mk(7'b0001000, 0, 0, 0, 2, 0, 0, 5), z, 2'b00,
                  "ADD after reset");

`ifdef MANO_INTERRUPT_EN
        run_instr(16'hF080, 5'b00000, 1, none(3), z, z, z, 2'b00, "ION");
        run_instr(16'h7800, 5'b00000, 1, mk(7'd0, 0, 3'b100, 0, 0, 0, 0, 3),
                  z, z, z, 2'b10, "CLA with FGI");
        step(mk(7'b0100000, 0, 3'b001, 2, 0, 0, 0, 0), "INT T0");
        step(mk(7'd0, 0, 3'b010, 6, 0, 0, 1, 1), "INT T1");
        step(mk(7'd0, 4'b0010, 0, 0, 0, 0, 0, 2), "INT T2");
        run_instr(16'h7800, 5'b00000, 1, mk(7'd0, 0, 3'b100, 0, 0, 0, 0, 3),
                  z, z, z, 2'b10, "CLA after INT");
        run_instr(16'hF200, 5'b00000, 1, mk(7'd0, 4'b0010, 0, 0, 0, 0, 0, 3),
                  z, z, z, 2'b10, "SKI");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
